// File: rtl/sum_window_accumulator.sv
// Accumulates a window of 2^WIN_LOG2 unsigned samples into a saturating total and
// holds total, average and saturation flag until the consumer takes them.
module sum_window_accumulator #(
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 16,
   parameter int WIN_LOG2 = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [ACC_W-1:0]    out_acc,
   output logic [DATA_W-1:0]   out_avg,
   output logic                out_sat,
   output logic [WIN_LOG2:0]   out_count,
   output logic                out_valid,
   input  logic                out_ready
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam logic [WIN_LOG2:0] LAST_IDX = (WIN_LOG2 + 1)'((1 << WIN_LOG2) - 1);
   localparam logic [WIN_LOG2:0] CNT_ONE  = (WIN_LOG2 + 1)'(1);

   state_t              state_r;
   logic [ACC_W-1:0]    acc_r;
   logic [WIN_LOG2:0]   count_r;
   logic                sat_r;
   logic                in_ready_r;
   logic                out_valid_r;

   logic [ACC_W:0]      sum_s;
   logic                ovf_s;
   logic [ACC_W-1:0]    acc_next_s;
   logic [DATA_W-1:0]   avg_s;
   logic                in_xfer_s;

   // Saturating add of the incoming sample and window average.
   always_comb begin
      sum_s     = {1'b0, acc_r} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
      ovf_s     = sum_s[ACC_W];
      in_xfer_s = in_valid && in_ready_r;
      if (ovf_s) begin
         acc_next_s = {ACC_W{1'b1}};
      end else begin
         acc_next_s = sum_s[ACC_W-1:0];
      end
      // Zero-extend first so bits above the accumulator read as 0 after the shift.
      if (sat_r) begin
         avg_s = {DATA_W{1'b1}};
      end else begin
         avg_s = DATA_W'({{(DATA_W + WIN_LOG2){1'b0}}, acc_r} >> WIN_LOG2);
      end
   end

   // Window state machine with registered handshake flags.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_r     <= ST_IDLE;
         acc_r       <= {ACC_W{1'b0}};
         count_r     <= {(WIN_LOG2 + 1){1'b0}};
         sat_r       <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_ACCUM: begin
               if (in_xfer_s) begin
                  acc_r   <= acc_next_s;
                  sat_r   <= sat_r | ovf_s;
                  count_r <= count_r + CNT_ONE;
                  if (count_r == LAST_IDX) begin
                     state_r     <= ST_HOLD;
                     in_ready_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                  end else begin
                     state_r <= ST_ACCUM;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state_r     <= ST_IDLE;
                  acc_r       <= {ACC_W{1'b0}};
                  count_r     <= {(WIN_LOG2 + 1){1'b0}};
                  sat_r       <= 1'b0;
                  in_ready_r  <= 1'b1;
                  out_valid_r <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               acc_r       <= {ACC_W{1'b0}};
               count_r     <= {(WIN_LOG2 + 1){1'b0}};
               sat_r       <= 1'b0;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_acc   = acc_r;
   assign out_sat   = sat_r;
   assign out_count = count_r;
   assign out_avg   = avg_s;

endmodule

// File: tb/tb_sum_window_accumulator.sv
// Directed bench: a default instance and an ACC_W=10 instance share the same stimulus.
module tb_sum_window_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;

   logic        a_in_ready, a_out_sat, a_out_valid;
   logic [15:0] a_out_acc;
   logic [7:0]  a_out_avg;
   logic [3:0]  a_out_count;

   logic        b_in_ready, b_out_sat, b_out_valid;
   logic [9:0]  b_out_acc;
   logic [7:0]  b_out_avg;
   logic [3:0]  b_out_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sum_window_accumulator dut_a (
      .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
      .in_ready(a_in_ready), .out_acc(a_out_acc), .out_avg(a_out_avg), .out_sat(a_out_sat),
      .out_count(a_out_count), .out_valid(a_out_valid), .out_ready(out_ready)
   );

   sum_window_accumulator #(.DATA_W(8), .ACC_W(10), .WIN_LOG2(3)) dut_b (
      .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
      .in_ready(b_in_ready), .out_acc(b_out_acc), .out_avg(b_out_avg), .out_sat(b_out_sat),
      .out_count(b_out_count), .out_valid(b_out_valid), .out_ready(out_ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Release a held window in both instances with no input offered.
   task automatic release_window();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0; clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            rst = 1'b0; in_valid = 1'b0;
         end
         tick();
         tests++;
         if ({a_out_valid, a_in_ready, a_out_count, a_out_acc} !== {1'b0, 1'b1, 4'd0, 16'd0}) begin
            fails++;
            $display("FAIL reset_%0d: valid=%b ready=%b count=%0d acc=%0d, expected valid=0 ready=1 count=0 acc=0",
                     i, a_out_valid, a_in_ready, a_out_count, a_out_acc);
         end
      end
   endtask

   task automatic test_basic_window();
      in_data = 8'd10; in_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         tests++;
         if ({a_out_valid, a_out_count, a_out_acc} !== {(i == 8), 4'(i), 16'(10 * i)}) begin
            fails++;
            $display("FAIL basic_step_%0d: valid=%b count=%0d acc=%0d, expected valid=%0d count=%0d acc=%0d",
                     i, a_out_valid, a_out_count, a_out_acc, (i == 8), i, 10 * i);
         end
      end
      tests++;
      if ({a_out_avg, a_out_sat, a_in_ready} !== {8'd10, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL basic_final: avg=%0d sat=%b ready=%b, expected avg=10 sat=0 ready=0",
                  a_out_avg, a_out_sat, a_in_ready);
      end
   endtask

   task automatic test_backpressure();
      in_data = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         tests++;
         if ({a_out_valid, a_in_ready, a_out_count, a_out_acc, a_out_avg} !==
             {1'b1, 1'b0, 4'd8, 16'd80, 8'd10}) begin
            fails++;
            $display("FAIL hold_%0d: valid=%b ready=%b count=%0d acc=%0d avg=%0d, expected 1 0 8 80 10",
                     i, a_out_valid, a_in_ready, a_out_count, a_out_acc, a_out_avg);
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests++;
      if ({a_out_valid, a_in_ready, a_out_count, a_out_acc} !== {1'b0, 1'b1, 4'd0, 16'd0}) begin
         fails++;
         $display("FAIL release: valid=%b ready=%b count=%0d acc=%0d, expected 0 1 0 0",
                  a_out_valid, a_in_ready, a_out_count, a_out_acc);
      end
      tick();
      tests++;
      if ({a_out_count, a_out_acc} !== {4'd1, 16'd255}) begin
         fails++;
         $display("FAIL first_after_release: count=%0d acc=%0d, expected count=1 acc=255",
                  a_out_count, a_out_acc);
      end
      in_valid = 1'b0; clear = 1'b1;
      tick();
      clear = 1'b0;
      tests++;
      if ({a_out_count, a_out_acc, a_in_ready} !== {4'd0, 16'd0, 1'b1}) begin
         fails++;
         $display("FAIL clear_partial: count=%0d acc=%0d ready=%b, expected 0 0 1",
                  a_out_count, a_out_acc, a_in_ready);
      end
   endtask

   task automatic test_saturation();
      rst = 1'b1; in_valid = 1'b0;
      tick();
      rst = 1'b0;
      in_data = 8'd200; in_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 5) begin
            tests++;
            if ({b_out_acc, b_out_sat} !== {10'd1000, 1'b0}) begin
               fails++;
               $display("FAIL sat_before: acc=%0d sat=%b, expected acc=1000 sat=0", b_out_acc, b_out_sat);
            end
         end else if (i == 6) begin
            tests++;
            if ({b_out_acc, b_out_sat} !== {10'h3FF, 1'b1}) begin
               fails++;
               $display("FAIL sat_onset: acc=%h sat=%b, expected acc=3ff sat=1", b_out_acc, b_out_sat);
            end
         end
      end
      in_valid = 1'b0;
      tests++;
      if ({b_out_valid, b_out_acc, b_out_sat, b_out_avg} !== {1'b1, 10'h3FF, 1'b1, 8'hFF}) begin
         fails++;
         $display("FAIL sat_window: valid=%b acc=%h sat=%b avg=%h, expected 1 3ff 1 ff",
                  b_out_valid, b_out_acc, b_out_sat, b_out_avg);
      end
      tests++;
      if ({a_out_valid, a_out_acc, a_out_sat, a_out_avg} !== {1'b1, 16'd1600, 1'b0, 8'd200}) begin
         fails++;
         $display("FAIL wide_window: valid=%b acc=%0d sat=%b avg=%0d, expected 1 1600 0 200",
                  a_out_valid, a_out_acc, a_out_sat, a_out_avg);
      end
      release_window();
      in_data = 8'd1; in_valid = 1'b1;
      repeat (8) tick();
      in_valid = 1'b0;
      tests++;
      if ({b_out_valid, b_out_acc, b_out_sat, b_out_avg} !== {1'b1, 10'd8, 1'b0, 8'd1}) begin
         fails++;
         $display("FAIL sat_cleared: valid=%b acc=%0d sat=%b avg=%0d, expected 1 8 0 1",
                  b_out_valid, b_out_acc, b_out_sat, b_out_avg);
      end
      release_window();
   endtask

   task automatic test_gapped();
      logic [7:0] samples [8];
      int         gaps [8];
      samples = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd9};
      gaps    = '{0, 1, 2, 3, 0, 2, 1, 3};
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b0;
         for (int g = 0; g < gaps[i]; g++) tick();
         in_data = samples[i]; in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      tests++;
      if ({a_out_valid, a_out_acc, a_out_avg, a_out_count} !== {1'b1, 16'd37, 8'd4, 4'd8}) begin
         fails++;
         $display("FAIL gapped: valid=%b acc=%0d avg=%0d count=%0d, expected 1 37 4 8",
                  a_out_valid, a_out_acc, a_out_avg, a_out_count);
      end
      release_window();
   endtask

   task automatic test_clear();
      in_data = 8'd50; in_valid = 1'b1;
      repeat (5) tick();
      tests++;
      if ({a_out_count, a_out_acc} !== {4'd5, 16'd250}) begin
         fails++;
         $display("FAIL clear_pre: count=%0d acc=%0d, expected count=5 acc=250", a_out_count, a_out_acc);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0; in_valid = 1'b0;
      tests++;
      if ({a_out_valid, a_in_ready, a_out_count, a_out_acc} !== {1'b0, 1'b1, 4'd0, 16'd0}) begin
         fails++;
         $display("FAIL clear_abort: valid=%b ready=%b count=%0d acc=%0d, expected 0 1 0 0",
                  a_out_valid, a_in_ready, a_out_count, a_out_acc);
      end
      in_data = 8'd3; in_valid = 1'b1;
      repeat (8) tick();
      in_valid = 1'b0;
      tests++;
      if ({a_out_valid, a_out_acc, a_out_avg} !== {1'b1, 16'd24, 8'd3}) begin
         fails++;
         $display("FAIL clear_next: valid=%b acc=%0d avg=%0d, expected 1 24 3",
                  a_out_valid, a_out_acc, a_out_avg);
      end
      release_window();
   endtask

   initial begin
      test_reset();
      test_basic_window();
      test_backpressure();
      test_saturation();
      test_gapped();
      test_clear();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sum_window_accumulator.md
# sum_window_accumulator

- Downstream stage of the 8-bit input-sum datapath.
- Consumes the stream of 8-bit sums over a valid/ready handshake and accumulates a window of 2^WIN_LOG2 samples into a saturating accumulator.
- At the end of each window it presents the total, the window average and a saturation flag to the output/readout logic, and holds them until that logic accepts them.

## Interface
Parameters:
- DATA_W, 8, width of each incoming sum sample
- ACC_W, 16, accumulator width; must be ≥ DATA_W
- WIN_LOG2, 3, log2 of samples per window (window = 8); range 1..7

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous abort: discard the current window, return to IDLE
- in_data  input  DATA_W  sum sample, unsigned
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block accepts a sample this cycle
- out_acc  output  ACC_W  window total, saturated
- out_avg  output  DATA_W  window average
- out_sat  output  1  accumulator saturated during this window
- out_count  output  WIN_LOG2+1  samples accepted in the current window
- out_valid  output  1  out_acc/out_avg/out_sat hold a finished window
- out_ready  input  1  consumer takes the finished window

## Operation
- An input transfer occurs when in_valid && in_ready at a rising edge. An output transfer occurs when out_valid && out_ready.
- State machine:
  - IDLE: acc=0, count=0, in_ready=1. An input transfer moves to ACCUM.
  - ACCUM: in_ready=1. Each input transfer does acc += in_data and count += 1. When the accepted sample is number 2^WIN_LOG2, move to HOLD.
  - HOLD: in_ready=0, out_valid=1. Outputs are frozen. An output transfer moves to IDLE, clearing acc, count and sat.
- Arithmetic:
  - in_data is zero-extended to ACC_W+1 bits before the add.
  - If the result exceeds 2^ACC_W−1, acc is set to all-ones and the sat flag is set. The sat flag is sticky until the window is consumed or cleared.
- out_avg:
  - If sat=1: all-ones.
  - Otherwise: bits acc[WIN_LOG2 +: DATA_W]. This is truncating division by the window size; when ACC_W < DATA_W+WIN_LOG2, the missing upper bits read as 0.
- out_acc and out_sat are driven from the registers at all times. out_avg is the combinational function of those registers. They are meaningful only while out_valid=1.
- out_count reads 0..2^WIN_LOG2. It is 2^WIN_LOG2 throughout HOLD.
- Priority: rst > clear > handshakes.
  - clear in any state: next cycle IDLE with acc, count and sat at 0.
  - Any input or output transfer coinciding with clear is discarded; its sample is not counted.
- A sample with in_data=0 still counts toward the window.

## Timing
- Reset values, one cycle after rst is sampled high:
  - state IDLE
  - in_ready=1, out_valid=0
  - out_acc=0, out_avg=0, out_sat=0, out_count=0
- Accept latency: a sample accepted at edge k is reflected in out_acc/out_count after edge k.
- Window latency: if the last sample is accepted at edge k, out_valid=1 and in_ready=0 from edge k onward. There is no extra pipeline cycle.
- Release: an output transfer at edge m gives out_valid=0 and in_ready=1 after edge m. The first sample of the next window is accepted at edge m+1 at the earliest.
- Best-case throughput is one window per 2^WIN_LOG2+1 cycles.
- in_valid may drop mid-window. Gaps do not affect the result.
- in_ready must not depend combinationally on in_valid. out_valid must not depend combinationally on out_ready.
- in_valid while in_ready=0 (HOLD) is ignored. The upstream must hold its data.

## Test plan
- Reset and idle: assert rst for 2 cycles with in_valid=1, in_data=0x55 → during and after reset out_valid=0, out_count=0, out_acc=0, in_ready=1.
- Basic window (defaults): 8 back-to-back samples of 10 → out_valid rises on the edge accepting sample 8; out_acc=80, out_avg=10, out_sat=0, out_count=8, in_ready=0.
- Backpressure: hold out_ready=0 for 5 cycles after the window completes, with in_valid=1, in_data=0xFF → outputs stable and in_ready=0 throughout. Then pulse out_ready=1 → the next cycle gives IDLE, out_valid=0, out_acc=0, and the 0xFF samples are accepted only from then on.
- Saturation: ACC_W=10, 8 samples of 200 → saturation on sample 6 (1200>1023); out_acc=0x3FF, out_sat=1, out_avg=0xFF. The next window of 8×1 gives out_acc=8, out_sat=0.
- Gapped input and truncation: samples 1,2,3,4,5,6,7,9 with 0–3 idle cycles between them → out_acc=37, out_avg=4.
- Clear mid-window: accept 5 samples of 50, then assert clear in the same cycle as a valid sample of 50 → next cycle IDLE, out_count=0, out_acc=0, and the coincident sample is not counted. Then 8×3 gives out_acc=24.
